data_mem_arbiter: RTL
=====================

# data_mem_arbiter

Two-port arbiter and load/store sequencer placed in front of the single-port data memory. It shares the memory between the pipeline MEM stage (port 0) and a secondary requester such as DMA or debug (port 1), and it issues at most one access per cycle. Loads get RISC-V lane extraction and sign/zero extension, and misaligned or illegal accesses are rejected before they reach the memory. Port 0 has fixed priority, with a starvation guard for port 1.

## Interface
- STARVE_LIMIT, 4: consecutive port-0 grants allowed while port 1 is waiting; the next grant then goes to port 1 (1..15).
- CLK  in  1  clock; all state updates on the rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- P0_REQ / P1_REQ  in  1  access request; held with its fields until the matching GNT.
- P0_WE / P1_WE  in  1  1 = store, 0 = load.
- P0_ADDR / P1_ADDR  in  32  byte address.
- P0_WDATA / P1_WDATA  in  32  store data, passed to memory unchanged.
- P0_FUNC3 / P1_FUNC3  in  3  RV32 load/store funct3.
- P0_GNT / P1_GNT  out  1  combinational; the request fields are captured at the end of this cycle.
- P0_DONE / P1_DONE  out  1  one-cycle completion pulse, for both loads and stores.
- P0_ERR / P1_ERR  out  1  valid only with DONE; 1 = access rejected.
- P0_RDATA / P1_RDATA  out  32  extended load result; holds until that port's next load DONE.
- MEM_ADDRESS  out  32  memory address.
- MEM_WRITE_DATA  out  32  memory write data.
- MEM_FUNC3  out  3  store type forwarded to memory.
- MEM_WRITE  out  1  memory write strobe.
- MEM_READ  out  1  memory read strobe.
- MEM_READ_DATA  in  32  asynchronous word read from memory.

## Operation
- Arbitration, every cycle:
  - Only P0 requesting: P0 wins. Only P1 requesting: P1 wins.
  - Both requesting: P0 wins unless STARVE_CNT == STARVE_LIMIT, in which case P1 wins.
  - At most one GNT is high per cycle. GNT is never high without the matching REQ.
- STARVE_CNT (4-bit):
  - +1 on a P0 grant while P1_REQ = 1 (saturates at STARVE_LIMIT).
  - Cleared on a P1 grant or whenever P1_REQ = 0.
- Issue register, loaded on each grant: valid, port, WE, ADDR, WDATA, FUNC3, err. It drives MEM_* in the next cycle. With no grant, valid = 0 and MEM_READ = MEM_WRITE = 0.
- Legality is checked at grant time:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000, 001, 010.
  - Any other funct3 is illegal.
  - LH/LHU/SH with ADDR[0] = 1 is misaligned; LW/SW with ADDR[1:0] != 0 is misaligned.
  - An illegal or misaligned access sets err. Its issue cycle drives no strobe, so memory is untouched.
- Issue cycle (valid, !err):
  - MEM_ADDRESS = ADDR, MEM_WRITE_DATA = WDATA, MEM_FUNC3 = FUNC3.
  - MEM_WRITE = WE, MEM_READ = !WE.
- Load extraction, registered at the end of the issue cycle:
  - Byte: lane ADDR[1:0] of MEM_READ_DATA (lane 0 = bits 7:0).
  - Half: bits 15:0 if ADDR[1] = 0, else bits 31:16.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
- Response stage, the cycle after issue:
  - DONE and ERR are driven for the issuing port.
  - RDATA updates only for a successful load; stores and errors leave RDATA unchanged.
- MEM_* outputs are 0 whenever no access is being issued.

## Timing
- Grant in cycle T, issue in T+1, DONE in T+2: 2-cycle latency.
- A write commits at the T+1/T+2 edge.
- Full throughput: a new grant can occur in every cycle, so issue and response overlap.
- Back-to-back store then load to the same word: the load issues after the store commits and returns the new data.
- Reset: RESET_N low asynchronously clears to 0 every output (GNT, DONE, ERR, RDATA, MEM_*), the issue and response registers, and STARVE_CNT.
- Reset during an issue cycle drops MEM_WRITE immediately: no commit and no DONE.
- First grant is possible in the first cycle after RESET_N rises, if REQ is high.

## Test plan
- Store then load through P0:
  - SW 0x8000_00FF to 0x10, then LB at 0x10 -> P0_RDATA = 0xFFFF_FFFF.
  - LBU at 0x13 -> 0x0000_0080.
  - LH at 0x12 -> 0xFFFF_8000.
  - Each DONE arrives exactly 2 cycles after its GNT.
- Contention with STARVE_LIMIT = 4: P0 and P1 both requesting continuously -> grant pattern P0,P0,P0,P0,P1, repeating. Neither port is ever unserved for more than 4 cycles.
- LW at 0x06 on P1 and funct3 011 on P0 -> ERR = 1 with DONE at T+2. MEM_READ and MEM_WRITE stay 0. RDATA is unchanged.
- Back-to-back P1 SW 0x1234_5678 to 0x20 at T and P0 LW 0x20 at T+1 -> P0_RDATA = 0x1234_5678 at T+3.
- Assert RESET_N low during the issue cycle of SW 0xDEAD_BEEF to 0x30:
  - All outputs go to 0 immediately; no DONE.
  - A later LW 0x30 returns the old value.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: two-port arbiter and load/store sequencer for the
// single-port data memory.
// Ports: clk, reset_n (async, active low);
//   p0_*/p1_*: req, we, addr, wdata, func3 in; gnt, done, err, rdata out;
//   mem_*: address, write_data, func3, write, read out; read_data in.
module data_mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  input  logic [2:0]  p0_func3,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  input  logic [2:0]  p1_func3,
  output logic        p0_gnt,
  output logic        p0_done,
  output logic        p0_err,
  output logic [31:0] p0_rdata,
  output logic        p1_gnt,
  output logic        p1_done,
  output logic        p1_err,
  output logic [31:0] p1_rdata,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic [2:0]  mem_func3,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [31:0] mem_read_data
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef struct packed {
    logic        v;
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic        err;
  } issue_t;

  issue_t      iss;
  logic [3:0]  starve_cnt;
  logic        rsp_v;
  logic        rsp_port;
  logic        rsp_err;
  logic        p1_win;
  logic        any_gnt;
  logic        go;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [2:0]  sel_f3;
  logic [31:0] lane;
  logic [31:0] ld_val;

  // Unknown funct3 or an access not naturally aligned to its size.
  function automatic logic illegal(
    input logic       we,
    input logic [2:0] f3,
    input logic [1:0] a
  );
    logic ok;
    ok = 1'b0;
    unique case (f3)
      3'b000:  ok = 1'b1;
      3'b001:  ok = ~a[0];
      3'b010:  ok = (a == 2'b00);
      3'b100:  ok = ~we;
      3'b101:  ok = ~we & ~a[0];
      default: ok = 1'b0;
    endcase
    return ~ok;
  endfunction

  // P1 overrides P0 only once P0 has used up its streak.
  assign p1_win  = reset_n & p1_req &
                   (~p0_req | (starve_cnt == LIMIT));
  assign p1_gnt  = p1_win;
  assign p0_gnt  = reset_n & p0_req & ~p1_win;
  assign any_gnt = p0_gnt | p1_gnt;

  assign sel_we    = p1_gnt ? p1_we    : p0_we;
  assign sel_addr  = p1_gnt ? p1_addr  : p0_addr;
  assign sel_wdata = p1_gnt ? p1_wdata : p0_wdata;
  assign sel_f3    = p1_gnt ? p1_func3 : p0_func3;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= '0;
    end else if (!p1_req || p1_gnt) begin
      starve_cnt <= '0;
    end else if (p0_gnt && starve_cnt != LIMIT) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      iss <= '0;
    end else begin
      iss.v <= any_gnt;
      if (any_gnt) begin
        iss.port  <= p1_gnt;
        iss.we    <= sel_we;
        iss.addr  <= sel_addr;
        iss.wdata <= sel_wdata;
        iss.f3    <= sel_f3;
        iss.err   <= illegal(sel_we, sel_f3,
                             sel_addr[1:0]);
      end
    end
  end

  // Rejected accesses still occupy the issue slot but never strobe.
  assign go = iss.v & ~iss.err;

  assign mem_address    = go ? iss.addr  : '0;
  assign mem_write_data = go ? iss.wdata : '0;
  assign mem_func3      = go ? iss.f3    : '0;
  assign mem_write      = go & iss.we;
  assign mem_read       = go & ~iss.we;

  assign lane = mem_read_data >> {iss.addr[1:0], 3'b000};

  always_comb begin
    ld_val = lane;
    unique case (iss.f3)
      3'b000:  ld_val = {{24{lane[7]}}, lane[7:0]};
      3'b001:  ld_val = {{16{lane[15]}}, lane[15:0]};
      3'b100:  ld_val = {24'd0, lane[7:0]};
      3'b101:  ld_val = {16'd0, lane[15:0]};
      default: ld_val = mem_read_data;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_v    <= 1'b0;
      rsp_port <= 1'b0;
      rsp_err  <= 1'b0;
      p0_rdata <= '0;
      p1_rdata <= '0;
    end else begin
      rsp_v    <= iss.v;
      rsp_port <= iss.port;
      rsp_err  <= iss.err;
      if (go && !iss.we && !iss.port) begin
        p0_rdata <= ld_val;
      end
      if (go && !iss.we && iss.port) begin
        p1_rdata <= ld_val;
      end
    end
  end

  assign p0_done = rsp_v & ~rsp_port;
  assign p1_done = rsp_v & rsp_port;
  assign p0_err  = p0_done & rsp_err;
  assign p1_err  = p1_done & rsp_err;

endmodule
